// File: rtl/thermometer_codec_stream_pkg.sv
// Shared mode codes, sweep direction type and thermometer helpers for the codec stream.
// Helpers work on 32-bit containers; callers truncate to their own width.
package thermo_pkg;

  localparam logic [1:0] MODE_ENC    = 2'b00;
  localparam logic [1:0] MODE_DEC    = 2'b01;
  localparam logic [1:0] MODE_SWEEP  = 2'b10;
  localparam logic [1:0] MODE_BYPASS = 2'b11;

  typedef enum logic {DIR_UP, DIR_DOWN} sweep_dir_t;

  function automatic logic [31:0] therm_encode(input logic [31:0] a);
    if (a >= 32'd32) return '1;
    return (32'd1 << a) - 32'd1;
  endfunction

  function automatic logic [31:0] therm_popcount(input logic [31:0] q);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n += {31'd0, q[i]};
    return n;
  endfunction

  // Valid thermometer: ones packed from bit 0, so adding one never carries into a set bit.
  function automatic logic therm_is_valid(input logic [31:0] q);
    return (q & (q + 32'd1)) == 32'd0;
  endfunction

  function automatic logic [31:0] therm_top(input logic [31:0] q);
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < 32; i++) if (q[i]) t = 32'(i + 1);
    return t;
  endfunction

endpackage

// File: rtl/thermometer_sweep_gen.sv
// Bar-graph sweep source: prescaler plus ping-pong level counter.
//   state    | meaning
//   DIR_UP   | level climbs toward W; at W the next step goes to W-1
//   DIR_DOWN | level falls toward 0; at 0 the next step goes to 1
module thermometer_sweep_gen
  import thermo_pkg::*;
#(
  parameter int K   = 3,
  parameter int W   = 7,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         advance,
  output logic         step,
  output logic [K-1:0] level
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_TC  = PW'(DIV - 1);
  localparam logic [K-1:0]  LVL_TOP = K'(W);

  logic [PW-1:0] presc;
  sweep_dir_t    dir;

  // The prescaler freezes while the slot is full so no level is ever skipped.
  assign step = enable && advance && (presc == PRE_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      level <= '0;
      dir   <= DIR_UP;
    end else if (!enable) begin
      presc <= '0;
      level <= '0;
      dir   <= DIR_UP;
    end else if (advance) begin
      if (presc == PRE_TC) begin
        presc <= '0;
        case (dir)
          DIR_UP: begin
            if (level == LVL_TOP) begin
              level <= level - 1'b1;
              dir   <= DIR_DOWN;
            end else begin
              level <= level + 1'b1;
            end
          end
          default: begin
            if (level == '0) begin
              level <= level + 1'b1;
              dir   <= DIR_UP;
            end else begin
              level <= level - 1'b1;
            end
          end
        endcase
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/thermometer_codec_stream.sv
// Thermometer encode/decode/bypass/sweep behind a single-register valid/ready slot,
// with bubble flagging and a saturating error counter.
module thermometer_codec_stream
  import thermo_pkg::*;
#(
  parameter int K     = 3,
  parameter int W     = 7,
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic         slot_free, sweep_en, sweep_step, accept, load, err_n;
  logic [K-1:0] level;
  logic [W-1:0] data_n;
  logic [31:0]  din_ext, a_ext;

  assign slot_free = !out_valid || out_ready;
  assign sweep_en  = (mode == MODE_SWEEP);
  assign in_ready  = slot_free && !sweep_en;
  assign accept    = in_valid && in_ready;
  assign load      = accept || sweep_step;
  assign din_ext   = 32'(in_data);

  thermometer_sweep_gen #(.K(K), .W(W), .DIV(DIV)) u_sweep (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (sweep_en),
    .advance (slot_free),
    .step    (sweep_step),
    .level   (level)
  );

  always_comb begin
    data_n = '0;
    err_n  = 1'b0;
    a_ext  = din_ext & ((32'd1 << K) - 32'd1);
    case (mode)
      MODE_ENC: begin
        if (a_ext > 32'(W)) begin
          data_n = '1;
          err_n  = 1'b1;
        end else begin
          data_n = W'(therm_encode(a_ext));
        end
      end
      MODE_DEC: begin
        if (therm_is_valid(din_ext)) begin
          data_n = W'(therm_popcount(din_ext));
        end else begin
          data_n = W'(therm_top(din_ext));
          err_n  = 1'b1;
        end
      end
      MODE_SWEEP: data_n = W'(therm_encode(32'(level)));
      default:    data_n = in_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= data_n;
        out_err   <= err_n;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (err_clr) err_count <= '0;
      else if (load && err_n && (err_count != CNT_MAX)) err_count <= err_count + 1'b1;
    end
  end

endmodule
